// File: rtl/rnd_arb_pkg.sv
// Shared types and constants for the random-number arbiter and its LFSR.
package rnd_arb_pkg;

    localparam int RND_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DELIVER
    } state_t;

endpackage

// File: rtl/lfsr_64bit.sv
// 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1) that advances 16 bits per enable,
// so each delivered word is a fresh, non-overlapping slice of the sequence.
module lfsr_64bit
    import rnd_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [RND_W-1:0] rnd_number
);

    localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF9;

    logic [63:0] state;
    logic [63:0] state_nxt;

    always_comb begin
        state_nxt = state;
        for (int i = 0; i < RND_W; i++) begin
            state_nxt = {state_nxt[62:0],
                         state_nxt[63] ^ state_nxt[62] ^ state_nxt[60] ^ state_nxt[59]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    assign rnd_number = state[RND_W-1:0];

endmodule

// File: rtl/rnd_arbiter.sv
// Round-robin arbiter handing out words from one shared LFSR; each delivery is
// preceded by exactly one LFSR advance so no two consecutive words share a state.
module rnd_arbiter
    import rnd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RND_W   = rnd_arb_pkg::RND_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stir_en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [RND_W-1:0]   rnd_data,
    output logic               busy
);

    localparam int PW = $clog2(NUM_REQ);

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    pick;
    logic             found;
    logic             lfsr_en;
    logic             release_gnt;
    logic [RND_W-1:0] rnd_number;

    lfsr_64bit u_lfsr (
        .clk        (clk),
        .rst_n      (~rst),
        .en         (lfsr_en),
        .rnd_number (rnd_number)
    );

    // Cyclic scan starting at ptr; first asserted request wins.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Abort (requester withdrew) is treated exactly like a consume.
    assign release_gnt = ack[winner] || !req[winner];

    always_comb begin
        state_nxt = state;
        lfsr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = STEP;
                end else begin
                    lfsr_en = stir_en;
                end
            end
            STEP: begin
                lfsr_en   = 1'b1;
                state_nxt = DELIVER;
            end
            DELIVER: begin
                if (release_gnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            rnd_valid <= (state_nxt == DELIVER);
            gnt       <= (state_nxt == DELIVER) ? (NUM_REQ'(1) << winner) : '0;
            if (state == IDLE && found) begin
                winner <= pick;
            end
            if (state == STEP) begin
                rnd_data <= rnd_number;
            end
            if (state == DELIVER && release_gnt) begin
                ptr <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rnd_arbiter.sv
// Bench for rnd_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of grants and LFSR advances.
module tb_rnd_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stir_en = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] ack = '0;
    logic [N-1:0] gnt;
    logic         rnd_valid;
    logic [15:0]  rnd_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rnd_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .stir_en   (stir_en),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] got, input logic [63:0] other);
        n_checks++;
        if (got === other) begin
            n_fail++;
            $display("FAIL %s: got %0h which must differ from %0h (t=%0t)", name, got, other, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase 0 = idle, 1 = advancing, 2 = delivering. m_adv counts LFSR advances
    // since reset; a delivered word is identified by the advance count it was taken at.
    bit          m_ok = 0;
    int          m_phase = 0;
    int          m_ptr = 0;
    int          m_w = 0;
    int          m_adv = 0;
    int          m_k = 0;
    int          m_epoch = 0;
    bit          m_new = 0;
    bit          m_any = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ok    = 1;
            m_phase = 0;
            m_ptr   = 0;
            m_adv   = 0;
            m_new   = 0;
            m_any   = 0;
            m_epoch++;
        end else if (m_ok) begin
            m_new = 0;
            case (m_phase)
                0: begin
                    if (req != '0) begin
                        bit f;
                        f = 0;
                        for (int j = 0; j < N; j++) begin
                            if (!f && req[(m_ptr + j) % N]) begin
                                f   = 1;
                                m_w = (m_ptr + j) % N;
                            end
                        end
                        m_phase = 1;
                    end else if (stir_en) begin
                        m_adv++;
                    end
                end
                1: begin
                    m_k     = m_adv;
                    m_adv++;
                    m_phase = 2;
                    m_new   = 1;
                    m_any   = 1;
                end
                default: begin
                    if (ack[m_w] || !req[m_w]) begin
                        m_phase = 0;
                        m_ptr   = (m_w + 1) % N;
                    end
                end
            endcase
        end
    end

    // Words seen per advance count; must replay identically after every reset.
    logic [15:0] c_seen[int];
    logic [15:0] c_hold = '0;
    logic [15:0] c_prev = '0;
    int          c_prev_epoch = -1;

    always @(negedge clk) begin
        if (m_ok) begin
            logic [N-1:0] eg;
            eg = '0;
            if (m_phase == 2) eg[m_w] = 1'b1;
            check("gnt", 64'(gnt), 64'(eg));
            check("rnd_valid", 64'(rnd_valid), 64'(m_phase == 2));
            check("busy", 64'(busy), 64'(m_phase != 0));
            if (!m_any) begin
                check("rnd_data_after_reset", 64'(rnd_data), 64'(0));
            end else if (m_phase == 2) begin
                if (m_new) begin
                    if (c_seen.exists(m_k)) check("rnd_data_replay", 64'(rnd_data), 64'(c_seen[m_k]));
                    else c_seen[m_k] = rnd_data;
                    if (c_prev_epoch == m_epoch) check_ne("rnd_data_fresh", 64'(rnd_data), 64'(c_prev));
                    c_prev       = rnd_data;
                    c_prev_epoch = m_epoch;
                    c_hold       = rnd_data;
                end else begin
                    check("rnd_data_stable", 64'(rnd_data), 64'(c_hold));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = '0; stir_en = 1'b0;
        tick();
        check("reset_gnt", 64'(gnt), 64'(0));
        check("reset_valid", 64'(rnd_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int w, output logic [15:0] word);
        int t;
        t = 0;
        w = -1;
        while (!rnd_valid && t < 20) begin
            tick();
            t++;
        end
        if (!rnd_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_gnt: no delivery within %0d cycles", t);
        end
        for (int i = 0; i < N; i++) if (gnt[i]) w = i;
        word = rnd_data;
    endtask

    task automatic finish_grant();
        ack = gnt; req = '0;
        tick();
        ack = '0;
        tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          w;
        logic [15:0] a, b;
        logic [15:0] words[5];

        // Single request, latency and pointer advance.
        do_reset();
        req = 4'b0100;
        tick();
        check("lat_step_valid", 64'(rnd_valid), 64'(0));
        tick();
        check("lat_gnt", 64'(gnt), 64'(4'b0100));
        check("lat_valid", 64'(rnd_valid), 64'(1));
        tick();
        tick();
        check("hold_gnt", 64'(gnt), 64'(4'b0100));
        ack = 4'b0100; req = '0;
        tick();
        check("ack_clears_gnt", 64'(gnt), 64'(0));
        ack = '0; req = 4'b1111;
        tick();
        tick();
        check("ptr_after_2", 64'(gnt), 64'(4'b1000));
        finish_grant();

        // All requesting: round-robin order and distinct words.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(w, words[i]);
            check("rr_order", 64'(w), 64'(i % 4));
            ack = gnt;
            tick();
            ack = '0;
        end
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                check_ne("rr_distinct", 64'(words[i]), 64'(words[j]));
        req = '0;
        tick();
        tick();

        // Foreign ack bits ignored.
        do_reset();
        req = 4'b0010;
        wait_gnt(w, a);
        check("foreign_winner", 64'(w), 64'(1));
        ack = 4'b1001;
        tick();
        check("foreign_gnt", 64'(gnt), 64'(4'b0010));
        check("foreign_data", 64'(rnd_data), 64'(a));
        ack = '0;
        tick();
        check("foreign_data2", 64'(rnd_data), 64'(a));
        ack = 4'b0010;
        tick();
        check("own_ack_gnt", 64'(gnt), 64'(0));
        ack = '0; req = '0;
        tick();

        // Abort by dropping req; next delivery uses a new word.
        do_reset();
        req = 4'b0001;
        wait_gnt(w, a);
        req = '0;
        tick();
        check("abort_gnt", 64'(gnt), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        req = 4'b0001;
        wait_gnt(w, b);
        check("abort_regrant", 64'(w), 64'(0));
        check_ne("abort_new_word", 64'(b), 64'(a));
        finish_grant();

        // Reset mid-delivery, then replay.
        do_reset();
        req = 4'b0100;
        wait_gnt(w, a);
        rst = 1'b1; req = '0;
        tick();
        check("midrst_gnt", 64'(gnt), 64'(0));
        check("midrst_valid", 64'(rnd_valid), 64'(0));
        check("midrst_data", 64'(rnd_data), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        rst = 1'b0; req = 4'b0100;
        wait_gnt(w, b);
        check("replay_word", 64'(b), 64'(a));
        finish_grant();

        // Stirring changes the first delivered word.
        do_reset();
        req = 4'b0001;
        wait_gnt(w, a);
        finish_grant();
        do_reset();
        stir_en = 1'b1;
        repeat (10) tick();
        stir_en = 1'b0; req = 4'b0001;
        wait_gnt(w, b);
        check_ne("stir_word", 64'(b), 64'(a));
        finish_grant();

        // Randomized traffic: the compare process checks every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst     = ($urandom % 150) == 0;
            stir_en = ($urandom % 3) == 0;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    ack[i] = 1'b0;
                    if ($urandom % 2) req[i] = 1'b0;
                end
                if (!req[i] && ($urandom % 5) == 0) req[i] = 1'b1;
                if (gnt[i]) begin
                    int r;
                    r = int'($urandom % 8);
                    if (r < 2) ack[i] = 1'b1;
                    else if (r == 2) req[i] = 1'b0;
                end else if (($urandom % 10) == 0) begin
                    ack[i] = 1'b1;
                end
            end
        end
        do_reset();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rnd_arbiter.md
RND_ARBITER -- requirements
Module: rnd_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one lfsr_64bit instance (2..8).
REQ-002 Parameter: RND_W, fixed 16, width of each delivered random word; equals lfsr_64bit rnd_number width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stir_en  input  1  when high, LFSR free-runs while the arbiter is idle with no requests.
REQ-006 req  input  NUM_REQ  per-requester request; held high until the matching ack.
REQ-007 ack  input  NUM_REQ  per-requester consume strobe; only the bit of the granted requester is honoured.
REQ-008 gnt  output  NUM_REQ  one-hot grant; all-zero when no delivery is in progress.
REQ-009 rnd_valid  output  1  rnd_data holds a fresh word for the granted requester.
REQ-010 rnd_data  output  RND_W  delivered random word.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, STEP, DELIVER; all outputs registered.
REQ-013 IDLE: if any req bit is high, latch the winner and go to STEP; otherwise stay in IDLE.
REQ-014 Winner: first asserted req bit scanning cyclically upward from pointer ptr (ptr, ptr+1, ... wrapping at NUM_REQ).
REQ-015 STEP: drive LFSR en high for exactly one cycle, then go to DELIVER; capture rnd_number into rnd_data on entry to DELIVER.
REQ-016 DELIVER: gnt = one-hot(winner), rnd_valid = 1, rnd_data held stable, LFSR en = 0.
REQ-017 Latency: req first sampled high in IDLE at cycle N -> rnd_valid and gnt high at cycle N+2.
REQ-018 DELIVER exit on ack[winner] = 1: go to IDLE, clear gnt and rnd_valid next cycle, ptr <= (winner+1) mod NUM_REQ.
REQ-019 DELIVER exit on req[winner] = 0 without ack (abort): identical to REQ-018; the word is discarded, never re-delivered.
REQ-020 ack bits other than ack[winner], and any ack outside DELIVER, are ignored.
REQ-021 Every delivered word is preceded by exactly one LFSR advance in STEP; consecutive deliveries never repeat the same LFSR state.
REQ-022 Stir: LFSR en = 1 in IDLE when stir_en = 1 and req == 0; otherwise LFSR en = 0 outside STEP.
REQ-023 Simultaneous ack and other pending req: return to IDLE first; new arbitration occurs in the following cycle (minimum 3-cycle spacing between deliveries).
REQ-024 ptr wraps from NUM_REQ-1 to 0; only one requester is granted at any time.

Reset
REQ-025 rst = 1 forces state IDLE, gnt = 0, rnd_valid = 0, rnd_data = 0, busy = 0, ptr = 0 on the next edge, from any state including mid-DELIVER.
REQ-026 LFSR instance reset driven as rst_n = ~rst, so LFSR reloads its fixed seed together with the arbiter.

Structure
REQ-027 Shared package rnd_arb_pkg holds the state enum (IDLE, STEP, DELIVER) and the RND_W constant.
REQ-028 One sub-module: lfsr_64bit, instantiated once, its en driven solely by this FSM.
REQ-029 Round-robin pick implemented inline (no separate module).

Verification
REQ-030 Reset then single req[2] held at cycle 0 -> gnt = 4'b0100, rnd_valid at cycle 2; ack[2] at cycle 4 -> gnt = 0 at cycle 5, ptr = 3.
REQ-031 req = 4'b1111 held, ack every grant -> grant order 0,1,2,3,0; all four rnd_data values pairwise distinct.
REQ-032 Grant req[1], pulse ack[0] and ack[3] during DELIVER -> no effect; rnd_data stable until ack[1].
REQ-033 Grant req[0], drop req[0] in DELIVER -> IDLE next cycle, ptr = 1, next pending req[0] delivers a different word.
REQ-034 Assert rst during DELIVER -> all outputs zero next cycle; repeating the same request sequence reproduces identical rnd_data.
REQ-035 stir_en = 1, idle 10 cycles, then req[0] -> rnd_data differs from the stir_en = 0 run of the same sequence.
